// File: rtl/core_pkg.sv
// Shared core types: memory-port ownership encoding and default bus widths.
package core_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 32;
  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_DATA = 2'd2
  } mem_owner_t;

endpackage : core_pkg

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins contention, but a streak counter forces a fetch grant after
// MAX_DATA_STREAK consecutive data grants while fetch is waiting. The read
// response comes back one cycle after the grant and is routed by a
// registered owner tag.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_resp_valid,
  output logic [DATA_WIDTH-1:0] if_resp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_resp_valid,
  output logic [DATA_WIDTH-1:0] d_resp_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic          grant_if;
  logic          grant_d;
  logic          streak_full;

  logic [SW-1:0] streak_q, streak_d;
  mem_owner_t    owner_q, owner_d;
  logic          flushed_q, flushed_d;  // fetch grant was flushed while being made
  logic          store_q, store_d;      // data grant was a store

  // Grant decision: data first unless fetch has starved for a full streak.
  always_comb begin
    streak_full = (streak_q == STREAK_MAX);
    grant_d     = 1'b0;
    grant_if    = 1'b0;
    if (!rst) begin
      grant_d  = d_req_valid && !(if_req_valid && streak_full);
      grant_if = if_req_valid && !grant_d;
    end
  end

  // Handshake and memory port, all driven straight from this cycle's grant.
  always_comb begin
    if_req_ready     = grant_if;
    d_req_ready      = grant_d;
    mem_write_enable = grant_d && d_write;
    mem_write_data   = d_wdata;
    mem_addr         = '0;
    if (grant_d) begin
      mem_addr = d_addr;
    end else if (grant_if) begin
      mem_addr = if_addr;
    end
  end

  // Next-state for streak counter and owner tag.
  always_comb begin
    streak_d  = streak_q;
    owner_d   = OWNER_NONE;
    flushed_d = 1'b0;
    store_d   = 1'b0;

    if (!if_req_valid || grant_if) begin
      streak_d = '0;
    end else if (grant_d && !streak_full) begin
      streak_d = streak_q + SW'(1);
    end

    if (grant_d) begin
      owner_d = OWNER_DATA;
      store_d = d_write;
    end else if (grant_if) begin
      owner_d   = OWNER_IF;
      flushed_d = if_flush;
    end
  end

  // State registers; reset discards any response that was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q  <= '0;
      owner_q   <= OWNER_NONE;
      flushed_q <= 1'b0;
      store_q   <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      owner_q   <= owner_d;
      flushed_q <= flushed_d;
      store_q   <= store_d;
    end
  end

  // Response routing: read data passes through from memory under the owner tag.
  // A flush in the response cycle also squashes a pending fetch response.
  always_comb begin
    if_resp_valid = (owner_q == OWNER_IF) && !flushed_q && !if_flush;
    if_resp_data  = if_resp_valid ? mem_read_data : '0;
    d_resp_valid  = (owner_q == OWNER_DATA);
    d_resp_data   = (d_resp_valid && !store_q) ? mem_read_data : '0;
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
  logic [31:0] if_addr, if_resp_data;
  logic        d_req_valid, d_req_ready, d_write, d_resp_valid;
  logic [31:0] d_addr, d_wdata, d_resp_data;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  logic [31:0] mem [256];
  logic [7:0]  midx;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        watch_d = 1'b0;
  logic        seen_d = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data), .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Memory model: word i initialised to 0xA000_0000 | i, one-cycle read latency.
  assign midx = mem_addr[9:2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
    end else if (mem_write_enable) begin
      mem[midx] <= mem_write_data;
    end
    mem_read_data <= mem[midx];
  end

  always @(d_resp_valid) if (watch_d && d_resp_valid) seen_d = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge; return at mid-cycle for checks.
  task automatic step(input logic ifv, input logic [31:0] ia, input logic fl,
                      input logic dv, input logic dw, input logic [31:0] da,
                      input logic [31:0] wd);
    @(posedge clk);
    #1;
    if_req_valid = ifv; if_addr = ia; if_flush = fl;
    d_req_valid = dv; d_write = dw; d_addr = da; d_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle(input logic fl);
    step(1'b0, 32'h0, fl, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [9:0] pat_c;
    logic [8:0] pat_s;
    logic       prev_d;
    pat_c = 10'b10_0001_0000;
    pat_s = 9'b1_0000_0000;

    rst = 1'b1;
    if_req_valid = 0; if_addr = 0; if_flush = 0;
    d_req_valid = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_if_resp_valid", if_resp_valid, 0);
    chk("rst_d_resp_valid", d_resp_valid, 0);
    chk("rst_if_resp_data", if_resp_data, 0);
    chk("rst_d_resp_data", d_resp_data, 0);
    chk("rst_mem_we", mem_write_enable, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Fetch only, back to back.
    step(1, 32'h0, 0, 0, 0, 0, 0);
    chk("fetch0_ready", if_req_ready, 1);
    chk("fetch0_addr", mem_addr, 32'h0);
    step(1, 32'h4, 0, 0, 0, 0, 0);
    chk("fetch1_ready", if_req_ready, 1);
    chk("fetch0_resp_valid", if_resp_valid, 1);
    chk("fetch0_resp_data", if_resp_data, 32'hA000_0000);
    step(1, 32'h8, 0, 0, 0, 0, 0);
    chk("fetch2_ready", if_req_ready, 1);
    chk("fetch1_resp_data", if_resp_data, 32'hA000_0001);
    idle(0);
    chk("fetch2_resp_valid", if_resp_valid, 1);
    chk("fetch2_resp_data", if_resp_data, 32'hA000_0002);
    idle(0);
    chk("fetch_done_valid", if_resp_valid, 0);

    // Contention: D,D,D,D,F,D,D,D,D,F.
    prev_d = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h40, 0, 1, 0, 32'h44, 0);
      chk($sformatf("cont%0d_if_ready", i), if_req_ready, pat_c[i]);
      chk($sformatf("cont%0d_d_ready", i), d_req_ready, !pat_c[i]);
      if (i > 0) chk($sformatf("cont%0d_d_resp", i), d_resp_valid, prev_d);
      prev_d = !pat_c[i];
    end
    idle(0);
    chk("cont_last_if_resp", if_resp_valid, 1);
    chk("cont_last_if_data", if_resp_data, 32'hA000_0010);

    // Streak clears on a cycle with fetch idle: D,D,D,(d only),D,D,D,D,F.
    for (int i = 0; i < 9; i++) begin
      step(i != 3, 32'h40, 0, 1, 0, 32'h44, 0);
      chk($sformatf("clr%0d_if_ready", i), if_req_ready, pat_s[i]);
    end
    idle(0);

    // Store then load same address.
    step(0, 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    chk("st_ready", d_req_ready, 1);
    chk("st_we", mem_write_enable, 1);
    chk("st_addr", mem_addr, 32'h10);
    chk("st_wdata", mem_write_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 1, 0, 32'h10, 0);
    chk("ld_we", mem_write_enable, 0);
    chk("st_resp_valid", d_resp_valid, 1);
    chk("st_resp_data", d_resp_data, 0);
    idle(0);
    chk("ld_resp_valid", d_resp_valid, 1);
    chk("ld_resp_data", d_resp_data, 32'hDEAD_BEEF);

    // Flush in response cycle, then a clean fetch.
    step(1, 32'h20, 0, 0, 0, 0, 0);
    idle(1);
    chk("flush_resp_valid", if_resp_valid, 0);
    step(1, 32'h24, 0, 0, 0, 0, 0);
    idle(0);
    chk("post_flush_valid", if_resp_valid, 1);
    chk("post_flush_data", if_resp_data, 32'hA000_0009);
    // Flush during the grant cycle suppresses the later response.
    step(1, 32'h28, 1, 0, 0, 0, 0);
    chk("flush_grant_ready", if_req_ready, 1);
    idle(0);
    chk("flush_grant_resp", if_resp_valid, 0);
    // Flush leaves data traffic alone.
    step(0, 0, 1, 1, 0, 32'h30, 0);
    idle(1);
    chk("flush_d_valid", d_resp_valid, 1);
    chk("flush_d_data", d_resp_data, 32'hA000_000C);

    // Reset one cycle after a load grant.
    step(0, 0, 0, 1, 0, 32'h14, 0);
    chk("pre_rst_ready", d_req_ready, 1);
    watch_d = 1'b1;
    rst = 1'b1;
    step(1, 32'h8, 0, 1, 1, 32'h18, 32'h1234_5678);
    chk("rstmid_d_valid", d_resp_valid, 0);
    chk("rstmid_if_valid", if_resp_valid, 0);
    chk("rstmid_d_ready", d_req_ready, 0);
    chk("rstmid_if_ready", if_req_ready, 0);
    chk("rstmid_we", mem_write_enable, 0);
    chk("rstmid_d_data", d_resp_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    if_req_valid = 0; d_req_valid = 0; d_write = 0;
    @(negedge clk);
    chk("rstrel_d_valid", d_resp_valid, 0);
    watch_d = 1'b0;
    chk("rst_no_d_resp_seen", seen_d, 0);
    step(0, 0, 0, 1, 0, 32'h14, 0);
    chk("post_rst_ready", d_req_ready, 1);
    idle(0);
    chk("post_rst_resp_valid", d_resp_valid, 1);
    chk("post_rst_resp_data", d_resp_data, 32'hA000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
